// File: rtl/ddr_frame_sched.sv
// Arbitrates one DDR command port between the SD loader (writes) and the
// display prefetch FIFO (reads), one fixed-length burst in flight at a time.
module ddr_frame_sched #(
   parameter int                ADDR_W      = 24,
   parameter int                BURST_LEN   = 32,
   parameter int                FRAME_WORDS = 393216,
   parameter logic [ADDR_W-1:0] RD_BASE     = '0,
   parameter logic [ADDR_W-1:0] WR_BASE     = '0,
   parameter int                FIFO_DEPTH  = 1024,
   parameter int                RD_LOW      = 256
) (
   input  logic              ddr_clk,
   input  logic              ddr_rst_n,
   input  logic              ddr_init_done,
   input  logic              frame_sync,
   input  logic              wr_addr_set,
   input  logic [10:0]       rd_fifo_level,
   input  logic [10:0]       wr_fifo_level,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_write,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [5:0]        cmd_len,
   input  logic              wdf_ready,
   output logic              wr_fifo_rden,
   input  logic              rd_data_valid,
   output logic              busy,
   output logic              wr_frame_done
);

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      RD_WAIT,
      WR_CMD,
      WR_DATA
   } state_t;

   localparam logic [ADDR_W-1:0] BL_A   = ADDR_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] RD_END = RD_BASE + ADDR_W'(FRAME_WORDS);
   localparam logic [ADDR_W-1:0] WR_END = WR_BASE + ADDR_W'(FRAME_WORDS);
   localparam logic [10:0]       LOW_LVL  = 11'(RD_LOW);
   localparam logic [10:0]       BL_LVL   = 11'(BURST_LEN);
   localparam logic [10:0]       FILL_LVL = 11'(FIFO_DEPTH - BURST_LEN);
   localparam logic [5:0]        LAST     = 6'(BURST_LEN - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [ADDR_W-1:0] rd_step, wr_step, rd_next, wr_next;
   logic [5:0]        beat_cnt;
   logic              fs_q, fs_fall;
   logic              rd_realign, rd_apply, wr_set_pend;
   logic              go_rd, go_wr, rd_done, wr_done, wr_wrap;
   logic              handshake, beat;

   assign cmd_len      = 6'(BURST_LEN);
   assign cmd_valid    = (state == RD_CMD) || (state == WR_CMD);
   assign busy         = (state != IDLE);
   assign wr_fifo_rden = (state == WR_DATA) && wdf_ready;
   assign handshake    = cmd_valid && cmd_ready;
   assign beat         = ((state == RD_WAIT) && rd_data_valid) || wr_fifo_rden;
   assign fs_fall      = fs_q && !frame_sync;

   assign rd_step = rd_addr + BL_A;
   assign rd_next = (rd_step == RD_END) ? RD_BASE : rd_step;
   assign wr_step = wr_addr + BL_A;
   assign wr_wrap = (wr_step == WR_END);
   assign wr_next = wr_wrap ? WR_BASE : wr_step;

   // Realign lands in IDLE/RD_CMD, or replaces the advance at read completion.
   assign rd_apply = rd_done || (state == IDLE) || (state == RD_CMD);

   always_comb begin
      state_nxt = state;
      go_rd     = 1'b0;
      go_wr     = 1'b0;
      rd_done   = 1'b0;
      wr_done   = 1'b0;
      unique case (state)
         IDLE: begin
            if (ddr_init_done) begin
               if (rd_fifo_level < LOW_LVL)
                  go_rd = 1'b1;
               else if (wr_fifo_level >= BL_LVL)
                  go_wr = 1'b1;
               else if (rd_fifo_level <= FILL_LVL)
                  go_rd = 1'b1;
            end
            if (go_rd) state_nxt = RD_CMD;
            if (go_wr) state_nxt = WR_CMD;
         end
         RD_CMD: if (cmd_ready) state_nxt = RD_WAIT;
         RD_WAIT: begin
            if (rd_data_valid && beat_cnt == LAST) begin
               rd_done   = 1'b1;
               state_nxt = IDLE;
            end
         end
         WR_CMD: if (cmd_ready) state_nxt = WR_DATA;
         WR_DATA: begin
            if (wdf_ready && beat_cnt == LAST) begin
               wr_done   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ddr_clk) begin
      if (!ddr_rst_n) begin
         state         <= IDLE;
         cmd_write     <= 1'b0;
         cmd_addr      <= '0;
         rd_addr       <= RD_BASE;
         wr_addr       <= WR_BASE;
         beat_cnt      <= '0;
         fs_q          <= 1'b1;
         rd_realign    <= 1'b0;
         wr_set_pend   <= 1'b0;
         wr_frame_done <= 1'b0;
      end else begin
         state         <= state_nxt;
         fs_q          <= frame_sync;
         wr_frame_done <= 1'b0;
         if (go_rd) begin
            cmd_write <= 1'b0;
            cmd_addr  <= rd_realign ? RD_BASE : rd_addr;
         end
         if (go_wr) begin
            cmd_write <= 1'b1;
            cmd_addr  <= wr_addr_set ? WR_BASE : wr_addr;
         end
         if (handshake)
            beat_cnt <= '0;
         else if (beat)
            beat_cnt <= beat_cnt + 6'd1;
         if (rd_realign && rd_apply)
            rd_addr <= RD_BASE;
         else if (rd_done)
            rd_addr <= rd_next;
         rd_realign <= fs_fall || (rd_realign && !rd_apply);
         if (state == WR_DATA) begin
            if (wr_done) begin
               wr_set_pend <= 1'b0;
               if (wr_addr_set || wr_set_pend) begin
                  wr_addr <= WR_BASE;
               end else begin
                  wr_addr       <= wr_next;
                  wr_frame_done <= wr_wrap;
               end
            end else if (wr_addr_set) begin
               wr_set_pend <= 1'b1;
            end
         end else if (wr_addr_set) begin
            wr_addr <= WR_BASE;
         end
      end
   end

endmodule

// File: tb/tb_ddr_frame_sched.sv
// Bench for ddr_frame_sched: arbitration table, directed corner sequences
// and a long randomized run against a transaction-level reference model.
module tb_ddr_frame_sched;

   localparam int          AW    = 24;
   localparam int          BL    = 32;
   localparam int          FW    = 8192;
   localparam int          DEPTH = 1024;
   localparam int          LOW   = 256;
   localparam logic [23:0] RB    = 24'h000000;
   localparam logic [23:0] WB    = 24'h010000;

   localparam int P_IDLE = 0, P_RCMD = 1, P_RWAIT = 2, P_WCMD = 3, P_WDATA = 4;

   logic          clk = 1'b0;
   logic          rst_n, init, fs, wset, ready, wdf, rdv;
   logic [10:0]   rl, wl;
   logic          cmd_valid, cmd_write, wr_fifo_rden, busy, wr_frame_done;
   logic [AW-1:0] cmd_addr;
   logic [5:0]    cmd_len;

   always #5 clk = ~clk;

   ddr_frame_sched #(
      .ADDR_W(AW), .BURST_LEN(BL), .FRAME_WORDS(FW),
      .RD_BASE(RB), .WR_BASE(WB), .FIFO_DEPTH(DEPTH), .RD_LOW(LOW)
   ) dut (
      .ddr_clk(clk), .ddr_rst_n(rst_n), .ddr_init_done(init),
      .frame_sync(fs), .wr_addr_set(wset),
      .rd_fifo_level(rl), .wr_fifo_level(wl),
      .cmd_valid(cmd_valid), .cmd_ready(ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdf_ready(wdf),
      .wr_fifo_rden(wr_fifo_rden), .rd_data_valid(rdv),
      .busy(busy), .wr_frame_done(wr_frame_done)
   );

   int vectors = 0;
   int miscompares = 0;
   int pop_cnt = 0;
   int hs_cnt = 0;
   int done_cnt = 0;

   // Reference model: pointers kept as frame offsets, wrapped with modulo.
   int          ph, beats, roff, woff;
   bit          rpend, wpend, prev_fs, m_valid, m_write, m_done;
   logic [23:0] m_addr;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   function automatic void m_reset();
      ph = P_IDLE; beats = 0; roff = 0; woff = 0;
      rpend = 0; wpend = 0; prev_fs = 1;
      m_valid = 0; m_write = 0; m_done = 0; m_addr = '0;
   endfunction

   task automatic m_step();
      bit fall;
      if (!rst_n) begin
         m_reset();
         return;
      end
      fall = prev_fs && !fs;
      prev_fs = fs;
      m_done = 0;
      case (ph)
         P_IDLE: begin
            if (rpend) begin roff = 0; rpend = 0; end
            if (wset) woff = 0;
            if (init) begin
               if (int'(rl) < LOW || (int'(wl) < BL && int'(rl) <= DEPTH - BL)) begin
                  ph = P_RCMD; m_write = 0; m_addr = RB + 24'(roff);
               end else if (int'(wl) >= BL) begin
                  ph = P_WCMD; m_write = 1; m_addr = WB + 24'(woff);
               end
            end
         end
         P_RCMD: begin
            if (rpend) begin roff = 0; rpend = 0; end
            if (wset) woff = 0;
            if (ready) begin ph = P_RWAIT; beats = 0; end
         end
         P_RWAIT: begin
            if (wset) woff = 0;
            if (rdv) begin
               beats++;
               if (beats == BL) begin
                  roff = rpend ? 0 : (roff + BL) % FW;
                  rpend = 0;
                  ph = P_IDLE;
               end
            end
         end
         P_WCMD: begin
            if (wset) woff = 0;
            if (ready) begin ph = P_WDATA; beats = 0; end
         end
         default: begin
            if (wdf) beats++;
            if (wdf && beats == BL) begin
               if (wpend || wset) woff = 0;
               else begin
                  woff = (woff + BL) % FW;
                  m_done = (woff == 0);
               end
               wpend = 0;
               ph = P_IDLE;
            end else if (wset) wpend = 1;
         end
      endcase
      if (fall) rpend = 1;
      m_valid = (ph == P_RCMD) || (ph == P_WCMD);
   endtask

   task automatic cyc();
      #1;
      chk("rden", wr_fifo_rden, (ph == P_WDATA) && wdf);
      if (wr_fifo_rden) pop_cnt++;
      if (cmd_valid && ready) hs_cnt++;
      m_step();
      @(posedge clk);
      #1;
      if (wr_frame_done) done_cnt++;
      chk("cmd_valid", cmd_valid, m_valid);
      chk("busy", busy, ph != P_IDLE);
      chk("frame_done", wr_frame_done, m_done);
      chk("cmd_len", cmd_len, BL);
      if (m_valid) begin
         chk("cmd_write", cmd_write, m_write);
         chk("cmd_addr", cmd_addr, m_addr);
      end
   endtask

   task automatic quiet();
      init = 1; fs = 1; wset = 0; ready = 1; wdf = 1; rdv = 0;
      rl = 11'd1000; wl = 11'd0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      cyc();
      rst_n = 1;
   endtask

   task automatic wait_valid(input int limit);
      for (int i = 0; i < limit; i++) begin
         if (cmd_valid) break;
         cyc();
      end
      chk("wait_valid", cmd_valid, 1);
   endtask

   task automatic wait_addr(input string name, input logic [23:0] a,
                            input int limit);
      for (int i = 0; i < limit; i++) begin
         if (cmd_valid && cmd_addr == a) break;
         cyc();
      end
      chk(name, cmd_addr, a);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, cmd_valid, 0);
      chk({tag, "_write"}, cmd_write, 0);
      chk({tag, "_addr"}, cmd_addr, 0);
      chk({tag, "_len"}, cmd_len, BL);
      chk({tag, "_rden"}, wr_fifo_rden, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, wr_frame_done, 0);
   endtask

   typedef struct {
      logic [10:0] rl;
      logic [10:0] wl;
      bit          init;
      bit          exp_v;
      bit          exp_w;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{11'd100,  11'd64, 1, 1, 0};
      tbl[1] = '{11'd255,  11'd32, 1, 1, 0};
      tbl[2] = '{11'd256,  11'd32, 1, 1, 1};
      tbl[3] = '{11'd256,  11'd31, 1, 1, 0};
      tbl[4] = '{11'd992,  11'd31, 1, 1, 0};
      tbl[5] = '{11'd993,  11'd31, 1, 0, 0};
      tbl[6] = '{11'd993,  11'd32, 1, 1, 1};
      tbl[7] = '{11'd1024, 11'd0,  1, 0, 0};
      tbl[8] = '{11'd0,    11'd64, 0, 0, 0};
      tbl[9] = '{11'd2047, 11'd63, 1, 1, 1};

      quiet();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      m_reset();
      chk_reset_vals("reset");
      rst_n = 1;

      // Calibration not done: demand on both sides but no command.
      init = 0; rl = 11'd0; wl = 11'd100;
      repeat (20) cyc();
      chk("init_low_valid", cmd_valid, 0);
      chk("init_low_busy", busy, 0);

      // Arbitration table, one decision per vector from a fresh reset.
      for (int i = 0; i < 10; i++) begin
         quiet();
         do_reset();
         rl = tbl[i].rl; wl = tbl[i].wl; init = tbl[i].init;
         cyc();
         chk("tbl_valid", cmd_valid, tbl[i].exp_v);
         if (tbl[i].exp_v) begin
            chk("tbl_write", cmd_write, tbl[i].exp_w);
            chk("tbl_addr", cmd_addr, tbl[i].exp_w ? WB : RB);
         end
      end

      // Priority: urgent read first, then write once the FIFO is healthy.
      quiet();
      do_reset();
      rl = 11'd100; wl = 11'd64;
      wait_valid(5);
      chk("prio_rd_write", cmd_write, 0);
      chk("prio_rd_addr", cmd_addr, 24'h000000);
      cyc();
      rl = 11'd900; rdv = 1;
      repeat (BL) cyc();
      rdv = 0;
      wait_valid(5);
      chk("prio_wr_write", cmd_write, 1);
      chk("prio_wr_addr", cmd_addr, WB);
      cyc();
      wl = 11'd0;
      pop_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         if (!busy) break;
         wdf = 1'($urandom_range(0, 1));
         cyc();
      end
      wdf = 1;
      chk("prio_pops", pop_cnt, BL);

      // Stall: cmd_ready low holds the command, then one handshake.
      quiet();
      do_reset();
      rl = 11'd100; ready = 0;
      wait_valid(5);
      hs_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("stall_valid", cmd_valid, 1);
         chk("stall_addr", cmd_addr, RB);
      end
      ready = 1;
      cyc();
      chk("stall_released", cmd_valid, 0);
      repeat (5) cyc();
      chk("stall_handshakes", hs_cnt, 1);

      // Write pointer wrap at the end of the frame.
      quiet();
      do_reset();
      wl = 11'd64;
      done_cnt = 0;
      wait_addr("wrap_addr", WB + 24'(FW - BL), (FW / BL) * 40);
      chk("wrap_no_early_done", done_cnt, 0);
      cyc();
      wait_valid(60);
      chk("wrap_done_once", done_cnt, 1);
      chk("wrap_next_addr", cmd_addr, WB);

      // Frame sync during a read burst realigns the next read.
      quiet();
      do_reset();
      rl = 11'd100; rdv = 1;
      wait_addr("realign_pre_addr", RB + 24'h001000, 140 * 40);
      cyc();
      repeat (5) cyc();
      fs = 0;
      repeat (3) cyc();
      fs = 1;
      chk("realign_in_burst", busy, 1);
      wait_valid(60);
      chk("realign_addr", cmd_addr, RB);

      // Reset in the middle of a write burst.
      quiet();
      do_reset();
      wl = 11'd64;
      wait_valid(5);
      cyc();
      wait_valid(60);
      chk("mid_second_addr", cmd_addr, WB + 24'(BL));
      cyc();
      repeat (5) cyc();
      rst_n = 0;
      cyc();
      chk_reset_vals("mid_reset");
      rst_n = 1;
      wait_valid(5);
      chk("mid_restart_write", cmd_write, 1);
      chk("mid_restart_addr", cmd_addr, WB);

      // Randomized traffic against the model.
      quiet();
      do_reset();
      for (int i = 0; i < 20000; i++) begin
         rst_n = ($urandom_range(0, 2999) != 0);
         init  = ($urandom_range(0, 15) != 0);
         rl    = 11'($urandom_range(0, 1100));
         wl    = 11'($urandom_range(0, 63));
         ready = ($urandom_range(0, 3) != 0);
         wdf   = ($urandom_range(0, 3) != 0);
         rdv   = ($urandom_range(0, 2) != 0);
         wset  = ($urandom_range(0, 199) == 0);
         if (fs) fs = ($urandom_range(0, 149) != 0);
         else    fs = ($urandom_range(0, 3) == 0);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors,
               miscompares);
      $finish;
   end

endmodule
